// File: rtl/inst_fetch_master.sv
// rtl/inst_fetch_master.sv - instruction-fetch initiator between pipeline control and the instruction ROM
module inst_fetch_master #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        rom_ack,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   pc;
    logic [CW-1:0] to_cnt;
    logic [31:0]   redirect_pc;
    logic          in_req;
    logic          slot_free;
    logic          capture;
    logic          unacked;
    logic          timeout_hit;

    assign redirect_pc = new_pc & 32'hFFFF_FFFC;
    assign in_req      = (state == REQ);
    assign slot_free   = !if_valid || !stall;
    assign capture     = in_req && rom_ack && slot_free && !flush;
    // An ack refused because the slot is full is not a timeout cycle; the ROM re-acks.
    assign unacked     = in_req && !rom_ack && slot_free;
    assign timeout_hit = unacked && (to_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = REQ;
                REQ:     state_nxt = timeout_hit ? ERR : REQ;
                ERR:     state_nxt = ERR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rom_ce = 1'b0;
        if (state == REQ) begin
            rom_ce = 1'b1;
        end
    end

    assign rom_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (flush) begin
            pc <= redirect_pc;
        end else if (capture) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (flush || !in_req || rom_ack) begin
            to_cnt <= '0;
        end else if (unacked) begin
            to_cnt <= timeout_hit ? '0 : to_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc    <= 32'h0;
            if_inst  <= 32'h0;
            if_valid <= 1'b0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (capture) begin
            if_pc    <= pc;
            if_inst  <= rom_inst;
            if_valid <= 1'b1;
        end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (flush) begin
            bus_err <= 1'b0;
        end else if (timeout_hit) begin
            bus_err <= 1'b1;
        end
    end

endmodule
